// File: rtl/seven_seg_scanner_pkg.sv
// Shared types, constants and helpers for the four-digit seven-segment scanner.
package seven_seg_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Digit k (k >= 1) is a leading zero when nibbles k..3 are all zero.
  function automatic logic is_lead_zero(input logic [15:0] v, input logic [1:0] idx);
    case (idx)
      2'd1:    return (v[15:4] == 12'h000);
      2'd2:    return (v[15:8] == 8'h00);
      2'd3:    return (v[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed hex display driver with per-digit blanking interval and
// once-per-frame value latching. All outputs are registered.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter bit SUPPRESS_LZ  = 1'b0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic [1:0]  digit_idx
);

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  state_t      state, state_n;
  logic        tick_prev;
  logic        adv;
  logic [15:0] latched, latched_n;
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  idx_n;
  logic [3:0]  nibble_n;
  logic [6:0]  seg_n;
  logic        dark_n;
  logic        lit_n;

  // Next-state values are computed here so the output registers can be loaded
  // from them, keeping outputs aligned with the state they describe.
  always_comb begin
    adv       = tick_in & ~tick_prev;
    state_n   = state;
    idx_n     = digit_idx;
    latched_n = latched;
    cnt_n     = cnt;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_n   = BLANK;
          idx_n     = 2'd0;
          latched_n = value;
          cnt_n     = 8'd0;
        end
        BLANK: begin
          cnt_n = cnt + 8'd1;
          if (cnt == BLANK_LAST) state_n = DRIVE;
        end
        DRIVE: begin
          if (adv) begin
            idx_n   = digit_idx + 2'd1;
            if (idx_n == 2'd0) latched_n = value;
            cnt_n   = 8'd0;
            state_n = BLANK;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    case (idx_n)
      2'd0:    nibble_n = latched_n[3:0];
      2'd1:    nibble_n = latched_n[7:4];
      2'd2:    nibble_n = latched_n[11:8];
      default: nibble_n = latched_n[15:12];
    endcase

    dark_n = blank[idx_n] | (SUPPRESS_LZ && is_lead_zero(latched_n, idx_n));
    lit_n  = (state_n == DRIVE) && !dark_n;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_n),
    .seg    (seg_n)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_prev <= 1'b0;
      latched   <= 16'h0000;
      cnt       <= 8'd0;
      digit_idx <= 2'd0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp_out    <= 1'b1;
    end else begin
      state     <= state_n;
      tick_prev <= tick_in;
      latched   <= latched_n;
      cnt       <= cnt_n;
      digit_idx <= idx_n;
      an        <= lit_n ? ~(4'b0001 << idx_n) : AN_OFF;
      seg       <= lit_n ? seg_n : SEG_OFF;
      dp_out    <= lit_n ? ~dp[idx_n] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: two instances (leading-zero suppression
// off and on) share stimulus; expected digit frames go through a queue.
module tb_seven_seg_scanner;

  logic        clk_in  = 1'b0;
  logic        reset   = 1'b0;
  logic        tick_in = 1'b0;
  logic        enable  = 1'b0;
  logic [15:0] value   = 16'h0000;
  logic [3:0]  dp      = 4'h0;
  logic [3:0]  blank   = 4'h0;

  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp_out0, dp_out1;
  logic [1:0] idx0, idx1;

  int total = 0;
  int bad   = 0;

  logic [27:0] exp_q[$];
  logic [15:0] m_latched = 16'h0000;
  logic [1:0]  m_idx     = 2'd0;

  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk_in = ~clk_in;

  seven_seg_scanner #(.BLANK_CYCLES(16), .SUPPRESS_LZ(1'b0)) dut0 (
    .clk_in (clk_in), .reset (reset), .tick_in (tick_in), .enable (enable),
    .value (value), .dp (dp), .blank (blank),
    .an (an0), .seg (seg0), .dp_out (dp_out0), .digit_idx (idx0)
  );

  seven_seg_scanner #(.BLANK_CYCLES(16), .SUPPRESS_LZ(1'b1)) dut1 (
    .clk_in (clk_in), .reset (reset), .tick_in (tick_in), .enable (enable),
    .value (value), .dp (dp), .blank (blank),
    .an (an1), .seg (seg1), .dp_out (dp_out1), .digit_idx (idx1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] obs0();
    return {an0, seg0, dp_out0, idx0};
  endfunction

  function automatic logic [13:0] obs1();
    return {an1, seg1, dp_out1, idx1};
  endfunction

  function automatic logic [13:0] off_vec(input logic [1:0] idx);
    return {4'hF, 7'h7F, 1'b1, idx};
  endfunction

  // Reference view of one driven digit: {an, seg, dp_out, digit_idx}.
  function automatic logic [13:0] model(input logic [15:0] lv, input int idx,
                                        input logic [3:0] dpv, input logic [3:0] blk,
                                        input bit lz);
    logic [3:0] nib;
    logic [3:0] an_e;
    logic       dark;
    nib  = lv[idx*4 +: 4];
    dark = blk[idx] || (lz && idx != 0 && (lv >> (idx*4)) == 16'h0000);
    an_e = 4'hF;
    an_e[idx] = 1'b0;
    if (dark) return {4'hF, 7'h7F, 1'b1, 2'(idx)};
    return {an_e, TBL[nib], ~dpv[idx], 2'(idx)};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The trigger (adv or enable) was applied at the preceding negedge.
  task automatic check_digit();
    logic [27:0] e;
    exp_q.push_back({model(m_latched, int'(m_idx), dp, blank, 1'b0),
                     model(m_latched, int'(m_idx), dp, blank, 1'b1)});
    repeat (16) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check("blank_lz0", obs0(), off_vec(m_idx));
      check("blank_lz1", obs1(), off_vec(m_idx));
    end
    @(posedge clk_in);
    @(negedge clk_in);
    e = exp_q.pop_front();
    check("drive_lz0", obs0(), e[27:14]);
    check("drive_lz1", obs1(), e[13:0]);
    repeat (8) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (8) @(negedge clk_in);
    check("hold_lz0", obs0(), e[27:14]);
    check("hold_lz1", obs1(), e[13:0]);
  endtask

  task automatic step_start();
    m_idx     = 2'd0;
    m_latched = value;
    check_digit();
  endtask

  task automatic step_adv();
    @(negedge clk_in);
    tick_in = 1'b1;
    m_idx   = m_idx + 2'd1;
    if (m_idx == 2'd0) m_latched = value;
    check_digit();
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("reset_lz0", obs0(), off_vec(2'd0));
    check("reset_lz1", obs1(), off_vec(2'd0));
    @(negedge clk_in);
    reset = 1'b1;
    repeat (5) @(negedge clk_in);
    check("idle_lz0", obs0(), off_vec(2'd0));
    check("idle_lz1", obs1(), off_vec(2'd0));

    // First frame of 12AF; value changes while digit 1 is shown.
    value = 16'h12AF;
    @(negedge clk_in);
    enable = 1'b1;
    step_start();
    step_adv();
    value = 16'h0000;
    step_adv();
    step_adv();
    repeat (4) step_adv();

    // Leading-zero suppression: 0050, then 0000.
    value = 16'h0050;
    repeat (4) step_adv();
    value = 16'h0000;
    repeat (4) step_adv();

    // Decimal point on digit 2, digit 3 forced dark.
    dp    = 4'b0100;
    blank = 4'b1000;
    value = 16'h12AF;
    repeat (4) step_adv();
    step_adv();
    step_adv();

    // Enable dropped together with an adv: idle, index held.
    @(negedge clk_in);
    tick_in = 1'b1;
    enable  = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("dis_lz0", obs0(), off_vec(m_idx));
    check("dis_lz1", obs1(), off_vec(m_idx));
    tick_in = 1'b0;
    repeat (5) @(negedge clk_in);
    check("dis_hold_lz0", obs0(), off_vec(m_idx));
    check("dis_hold_lz1", obs1(), off_vec(m_idx));

    // Re-enable picks up a fresh value from digit 0.
    dp    = 4'b0000;
    blank = 4'b0000;
    value = 16'hBEEF;
    @(negedge clk_in);
    enable = 1'b1;
    step_start();
    step_adv();
    step_adv();

    // Asynchronous reset in the middle of digit 2.
    #2;
    reset = 1'b0;
    #1;
    m_idx = 2'd0;
    check("async_rst_lz0", obs0(), off_vec(2'd0));
    check("async_rst_lz1", obs1(), off_vec(2'd0));
    @(negedge clk_in);
    reset = 1'b1;
    step_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
